// File: rtl/pulse_blinker.sv
// pulse_blinker: turns a single-cycle trig pulse into N timed LED blinks.
// Each blink is ON_CYCLES lit followed by OFF_CYCLES unlit, except that the
// last blink has no trailing off phase. busy covers the whole sequence and
// done pulses for one cycle right after the final on phase.
module pulse_blinker #(
  parameter int unsigned ON_CYCLES   = 25000000,
  parameter int unsigned OFF_CYCLES  = 25000000,
  parameter int unsigned CNT_W       = 32,
  parameter bit          ACTIVE_HIGH = 1'b1,
  parameter bit          RETRIGGER   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [3:0] n_blinks,
  output logic       led,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // Last count value of each phase; the counter runs 0..LEN-1 and is cleared
  // on every phase transition, so it never wraps.
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  // LED level while not lit.
  localparam logic LED_IDLE = ~ACTIVE_HIGH;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       remaining_reg, remaining_next;
  logic             led_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             lit_next;

  // A trig while a sequence is running only matters when retriggering is on.
  logic restart;
  assign restart = RETRIGGER && trig;

  // State, counters and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      remaining_reg <= '0;
      led_reg       <= LED_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      remaining_reg <= remaining_next;
      led_reg       <= ACTIVE_HIGH ? lit_next : ~lit_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  // Next-state logic: phase sequencing, blink countdown and (re)start handling.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    remaining_next = remaining_reg;
    lit_next       = (state_reg == ON);
    busy_next      = (state_reg != IDLE);
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        lit_next  = 1'b0;
        busy_next = 1'b0;
        if (trig && (n_blinks != 4'd0)) begin
          state_next     = ON;
          cnt_next       = '0;
          remaining_next = n_blinks;
          lit_next       = 1'b1;
          busy_next      = 1'b1;
        end
      end

      ON: begin
        if (cnt_reg == ON_LAST) begin
          cnt_next       = '0;
          remaining_next = remaining_reg - 4'd1;
          if (remaining_reg == 4'd1) begin
            // Final blink ends without an off phase.
            state_next = IDLE;
            lit_next   = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = OFF;
            lit_next   = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      OFF: begin
        if (cnt_reg == OFF_LAST) begin
          state_next = ON;
          cnt_next   = '0;
          lit_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        lit_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase

    // A retrigger overrides whatever the running phase would have done,
    // including a phase end in the same cycle, so no done fires then.
    if (restart && (state_reg != IDLE)) begin
      cnt_next = '0;
      if (n_blinks == 4'd0) begin
        state_next     = IDLE;
        remaining_next = '0;
        lit_next       = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b1;
      end else begin
        state_next     = ON;
        remaining_next = n_blinks;
        lit_next       = 1'b1;
        busy_next      = 1'b1;
        done_next      = 1'b0;
      end
    end
  end

  assign led  = led_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed testbench for pulse_blinker with ON_CYCLES=3, OFF_CYCLES=2.
// Three instances: default (no retrigger, active-high), retrigger, active-low.
// Expected waveforms are hand-written bit strings, MSB = cycle T (trig cycle).
module tb_pulse_blinker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [3:0] nb = 4'd0;
  int         sel = 0;

  logic trig0, trig1, trig2;
  logic led0, busy0, done0;
  logic led1, busy1, done1;
  logic led2, busy2, done2;
  logic obs_led, obs_busy, obs_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign trig0 = trig && (sel == 0);
  assign trig1 = trig && (sel == 1);
  assign trig2 = trig && (sel == 2);

  always_comb begin
    obs_led  = led0;
    obs_busy = busy0;
    obs_done = done0;
    if (sel == 1) begin
      obs_led = led1; obs_busy = busy1; obs_done = done1;
    end else if (sel == 2) begin
      obs_led = led2; obs_busy = busy2; obs_done = done2;
    end
  end

  pulse_blinker #(.ON_CYCLES(3), .OFF_CYCLES(2), .CNT_W(8), .ACTIVE_HIGH(1'b1), .RETRIGGER(1'b0)) dut (
    .clk(clk), .rst(rst), .trig(trig0), .n_blinks(nb), .led(led0), .busy(busy0), .done(done0));

  pulse_blinker #(.ON_CYCLES(3), .OFF_CYCLES(2), .CNT_W(8), .ACTIVE_HIGH(1'b1), .RETRIGGER(1'b1)) dut_rt (
    .clk(clk), .rst(rst), .trig(trig1), .n_blinks(nb), .led(led1), .busy(busy1), .done(done1));

  pulse_blinker #(.ON_CYCLES(3), .OFF_CYCLES(2), .CNT_W(8), .ACTIVE_HIGH(1'b0), .RETRIGGER(1'b0)) dut_al (
    .clk(clk), .rst(rst), .trig(trig2), .n_blinks(nb), .led(led2), .busy(busy2), .done(done2));

  task automatic test_reset();
    // Initial reset values on all instances.
    repeat (2) @(negedge clk);
    n_vec++;
    if ({led0, busy0, done0, led1, busy1, done1, led2, busy2, done2} !== 9'b000_000_100) begin
      n_bad++;
      $display("FAIL reset_init: got %b expected %b", {led0, busy0, done0, led1, busy1, done1, led2, busy2, done2}, 9'b000_000_100);
    end
    rst = 1'b0;
    // Start a 3-blink sequence and abort it mid-ON with an async reset.
    sel = 0;
    @(negedge clk); trig = 1'b1; nb = 4'd3;
    @(negedge clk); trig = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({led0, busy0} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_pre_on: got led,busy=%b expected 11", {led0, busy0});
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({led0, busy0, done0, led2} !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_async: got led,busy,done,led_al=%b expected 0001", {led0, busy0, done0, led2});
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({led0, busy0, done0} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_after cyc%0d: got %b expected 000", i, {led0, busy0, done0});
      end
    end
  endtask

  task automatic test_single_blink();
    logic [15:0] e_led  = 16'b0111_0000_0000_0000;
    logic [15:0] e_busy = 16'b0111_0000_0000_0000;
    logic [15:0] e_done = 16'b0000_1000_0000_0000;
    sel = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_vec++;
      if ({obs_led, obs_busy, obs_done} !== {e_led[15-i], e_busy[15-i], e_done[15-i]}) begin
        n_bad++;
        $display("FAIL single_blink T+%0d: got %b expected %b", i, {obs_led, obs_busy, obs_done}, {e_led[15-i], e_busy[15-i], e_done[15-i]});
      end
      trig = (i == 0); nb = 4'd1;
    end
    trig = 1'b0;
  endtask

  task automatic test_three_blinks();
    logic [15:0] e_led  = 16'b0111_0011_1001_1100;
    logic [15:0] e_busy = 16'b0111_1111_1111_1100;
    logic [15:0] e_done = 16'b0000_0000_0000_0010;
    sel = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_vec++;
      if ({obs_led, obs_busy, obs_done} !== {e_led[15-i], e_busy[15-i], e_done[15-i]}) begin
        n_bad++;
        $display("FAIL three_blinks T+%0d: got %b expected %b", i, {obs_led, obs_busy, obs_done}, {e_led[15-i], e_busy[15-i], e_done[15-i]});
      end
      trig = (i == 0); nb = 4'd3;
    end
    trig = 1'b0;
  endtask

  task automatic test_zero_trig();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        n_vec++;
        if ({obs_led, obs_busy, obs_done} !== 3'b000) begin
          n_bad++;
          $display("FAIL zero_trig inst%0d T+%0d: got %b expected 000", s, i, {obs_led, obs_busy, obs_done});
        end
        trig = (i == 0); nb = 4'd0;
      end
      trig = 1'b0;
    end
  endtask

  task automatic test_ignored_trig();
    // Second trig (n_blinks=5) mid-sequence must not change a 1-blink run.
    logic [15:0] e_led  = 16'b0111_0000_0000_0000;
    logic [15:0] e_busy = 16'b0111_0000_0000_0000;
    logic [15:0] e_done = 16'b0000_1000_0000_0000;
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if ({obs_led, obs_busy, obs_done} !== {e_led[15-i], e_busy[15-i], e_done[15-i]}) begin
        n_bad++;
        $display("FAIL ignored_trig T+%0d: got %b expected %b", i, {obs_led, obs_busy, obs_done}, {e_led[15-i], e_busy[15-i], e_done[15-i]});
      end
      trig = (i == 0) || (i == 2);
      nb   = (i == 0) ? 4'd1 : 4'd5;
    end
    trig = 1'b0;
  endtask

  task automatic test_retrigger();
    // n=2 at T, n=1 at T+2: lit T+1..T+5, done at T+6.
    logic [15:0] e_led  = 16'b0111_1100_0000_0000;
    logic [15:0] e_busy = 16'b0111_1100_0000_0000;
    logic [15:0] e_done = 16'b0000_0010_0000_0000;
    sel = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if ({obs_led, obs_busy, obs_done} !== {e_led[15-i], e_busy[15-i], e_done[15-i]}) begin
        n_bad++;
        $display("FAIL retrigger T+%0d: got %b expected %b", i, {obs_led, obs_busy, obs_done}, {e_led[15-i], e_busy[15-i], e_done[15-i]});
      end
      trig = (i == 0) || (i == 2);
      nb   = (i == 0) ? 4'd2 : 4'd1;
    end
    trig = 1'b0;
  endtask

  task automatic test_retrigger_abort();
    // n=3 at T, n=0 at T+2: abort, done at T+3.
    logic [15:0] e_led  = 16'b0110_0000_0000_0000;
    logic [15:0] e_busy = 16'b0110_0000_0000_0000;
    logic [15:0] e_done = 16'b0001_0000_0000_0000;
    sel = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({obs_led, obs_busy, obs_done} !== {e_led[15-i], e_busy[15-i], e_done[15-i]}) begin
        n_bad++;
        $display("FAIL retrigger_abort T+%0d: got %b expected %b", i, {obs_led, obs_busy, obs_done}, {e_led[15-i], e_busy[15-i], e_done[15-i]});
      end
      trig = (i == 0) || (i == 2);
      nb   = (i == 0) ? 4'd3 : 4'd0;
    end
    trig = 1'b0;
  endtask

  task automatic test_back_to_back();
    // n=1 at T, n=2 at T+4 (the done cycle): no gap lost.
    logic [15:0] e_led  = 16'b0111_0111_0011_1000;
    logic [15:0] e_busy = 16'b0111_0111_1111_1000;
    logic [15:0] e_done = 16'b0000_1000_0000_0100;
    sel = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_vec++;
      if ({obs_led, obs_busy, obs_done} !== {e_led[15-i], e_busy[15-i], e_done[15-i]}) begin
        n_bad++;
        $display("FAIL back_to_back T+%0d: got %b expected %b", i, {obs_led, obs_busy, obs_done}, {e_led[15-i], e_busy[15-i], e_done[15-i]});
      end
      trig = (i == 0) || (i == 4);
      nb   = (i == 0) ? 4'd1 : 4'd2;
    end
    trig = 1'b0;
  endtask

  task automatic test_polarity();
    // Active-low instance: led is the inverse of the single-blink waveform.
    logic [15:0] e_led  = 16'b1000_1111_1111_1111;
    logic [15:0] e_busy = 16'b0111_0000_0000_0000;
    logic [15:0] e_done = 16'b0000_1000_0000_0000;
    sel = 2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_vec++;
      if ({obs_led, obs_busy, obs_done} !== {e_led[15-i], e_busy[15-i], e_done[15-i]}) begin
        n_bad++;
        $display("FAIL polarity T+%0d: got %b expected %b", i, {obs_led, obs_busy, obs_done}, {e_led[15-i], e_busy[15-i], e_done[15-i]});
      end
      trig = (i == 0); nb = 4'd1;
    end
    trig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_blink();
    test_three_blinks();
    test_zero_trig();
    test_ignored_trig();
    test_retrigger();
    test_retrigger_abort();
    test_back_to_back();
    test_polarity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
